// File: rtl/pmu_quota_pkg.sv
// Shared types and sizing helpers for the PMU quota scheduler.
// Optional build macro QUOTA_EARLY_EXIT_EN is consumed by pmu_quota_sched.
package pmu_quota_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_CLEAR,
      ST_ACCUM,
      ST_CHECK
   } state_e;

   localparam int DEF_REG_WIDTH    = 32;
   localparam int DEF_N_COUNTERS   = 9;
   localparam int DEF_N_CORES      = 4;
   localparam int DEF_PERIOD_WIDTH = 32;

   function automatic int calc_max_w(input int rw, input int ncnt);
      return rw + $clog2(ncnt);
   endfunction

   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/pmu_quota_period_timer.sv
// Replenishment window timer; wrap_o marks the last cycle of a window.
// A zero period stops the timer and suppresses the boundary.
module pmu_quota_period_timer #(
   parameter int PERIOD_WIDTH = 32
) (
   input  logic                    clk_i,
   input  logic                    clr_i,
   input  logic                    en_i,
   input  logic [PERIOD_WIDTH-1:0] period_i,
   output logic                    wrap_o
);

   logic [PERIOD_WIDTH-1:0] timer_q;
   logic                    cnt_en;
   logic                    wrap;

   assign cnt_en = en_i && (period_i != '0);
   // >= so a shortened period fires on the next counting cycle
   assign wrap   = cnt_en && (timer_q >= period_i - 1'b1);
   assign wrap_o = wrap && !clr_i;

   // window counter, restarts at each boundary
   always_ff @(posedge clk_i) begin
      if (clr_i) begin
         timer_q <= '0;
      end else if (wrap) begin
         timer_q <= '0;
      end else if (cnt_en) begin
         timer_q <= timer_q + 1'b1;
      end
   end

endmodule

// File: rtl/pmu_quota_sched.sv
// Round-robin quota scheduler sharing one adder across all cores.
// Define QUOTA_EARLY_EXIT_EN to leave ACCUM as soon as the limit is passed.
module pmu_quota_sched
   import pmu_quota_pkg::*;
#(
   parameter  int REG_WIDTH    = DEF_REG_WIDTH,
   parameter  int N_COUNTERS   = DEF_N_COUNTERS,
   parameter  int N_CORES      = DEF_N_CORES,
   parameter  int PERIOD_WIDTH = DEF_PERIOD_WIDTH,
   localparam int MAX_W        = calc_max_w(REG_WIDTH, N_COUNTERS)
) (
   input  logic                                  clk_i,
   input  logic                                  rst_i,
   input  logic                                  softrst_i,
   input  logic                                  enable_i,
   input  logic [N_COUNTERS-1:0][REG_WIDTH-1:0]  counter_value_i,
   input  logic [N_CORES-1:0][N_COUNTERS-1:0]    quota_mask_i,
   input  logic [N_CORES-1:0][MAX_W-1:0]         quota_limit_i,
   input  logic [PERIOD_WIDTH-1:0]               period_i,
   input  logic [N_CORES-1:0]                    intr_clr_i,
   output logic                                  window_rst_o,
   output logic [N_CORES-1:0]                    intr_quota_o,
   output logic                                  busy_o
);

   localparam int CW = idx_w(N_CORES);
   localparam int NW = idx_w(N_COUNTERS);
   localparam logic [CW-1:0] LAST_CORE = CW'(N_CORES - 1);
   localparam logic [NW-1:0] LAST_CNT  = NW'(N_COUNTERS - 1);

   logic                               clr;
   state_e                             state_q, state_d, resume_q;
   logic [CW-1:0]                      core_q;
   logic [NW-1:0]                      cnt_q;
   logic [MAX_W-1:0]                   acc_q, acc_sum;
   logic [N_CORES-1:0][N_COUNTERS-1:0] old_mask_q;
   logic [N_CORES-1:0]                 intr_q, intr_d;
   logic [REG_WIDTH-1:0]               term;
   logic                               wrap, abort, last_cnt;

   assign clr = rst_i | softrst_i;

   pmu_quota_period_timer #(
      .PERIOD_WIDTH(PERIOD_WIDTH)
   ) u_timer (
      .clk_i   (clk_i),
      .clr_i   (clr),
      .en_i    (enable_i),
      .period_i(period_i),
      .wrap_o  (wrap)
   );

   // a window boundary or any mask edit restarts the sweep at core 0
   assign abort    = wrap || (quota_mask_i != old_mask_q);
   assign last_cnt = (cnt_q == LAST_CNT);
   assign term     = quota_mask_i[core_q][cnt_q] ?
                     counter_value_i[cnt_q] : '0;
   assign acc_sum  = acc_q + MAX_W'(term);

`ifdef QUOTA_EARLY_EXIT_EN
   logic over;
   assign over = acc_sum > quota_limit_i[core_q];
`endif

   // state and resume registers
   always_ff @(posedge clk_i) begin
      if (clr) begin
         state_q  <= ST_CLEAR;
         resume_q <= ST_CLEAR;
      end else begin
         state_q <= state_d;
         if (!enable_i && state_q != ST_IDLE) begin
            resume_q <= state_q;
         end
      end
   end

   // next-state selection
   always_comb begin
      state_d = state_q;
      if (!enable_i) begin
         state_d = ST_IDLE;
      end else if (abort) begin
         state_d = ST_CLEAR;
      end else begin
         unique case (state_q)
            ST_IDLE:  state_d = resume_q;
            ST_CLEAR: state_d = ST_ACCUM;
            ST_ACCUM: begin
               if (last_cnt) begin
                  state_d = ST_CHECK;
`ifdef QUOTA_EARLY_EXIT_EN
               end else if (over) begin
                  state_d = ST_CHECK;
`endif
               end
            end
            ST_CHECK: state_d = ST_CLEAR;
            default:  state_d = ST_CLEAR;
         endcase
      end
   end

   // sticky interrupts: boundary clear beats CHECK set beats sw clear
   always_comb begin
      intr_d = intr_q & ~intr_clr_i;
      if (state_q == ST_CHECK && !abort &&
          acc_q > quota_limit_i[core_q]) begin
         intr_d[core_q] = 1'b1;
      end
      if (wrap) begin
         intr_d = '0;
      end
   end

   // scan datapath: core/counter indices, accumulator, mask history
   always_ff @(posedge clk_i) begin
      if (clr) begin
         core_q     <= '0;
         cnt_q      <= '0;
         acc_q      <= '0;
         old_mask_q <= '0;
         intr_q     <= '0;
      end else if (enable_i) begin
         old_mask_q <= quota_mask_i;
         intr_q     <= intr_d;
         if (abort) begin
            core_q <= '0;
            cnt_q  <= '0;
            acc_q  <= '0;
         end else begin
            unique case (state_q)
               ST_CLEAR: begin
                  acc_q <= '0;
                  cnt_q <= '0;
               end
               ST_ACCUM: begin
                  acc_q <= acc_sum;
                  cnt_q <= last_cnt ? '0 : cnt_q + 1'b1;
               end
               ST_CHECK: begin
                  core_q <= (core_q == LAST_CORE) ?
                            '0 : core_q + 1'b1;
               end
               default: ;
            endcase
         end
      end
   end

   // registered-state outputs
   always_comb begin
      busy_o       = (state_q == ST_ACCUM) ||
                     (state_q == ST_CHECK);
      intr_quota_o = intr_q;
      window_rst_o = wrap;
   end

endmodule

// File: doc/pmu_quota_sched.md
Name: pmu_quota_sched

Overview:
Time-multiplexed quota scheduler for N_CORES cores sharing one accumulation adder over a common PMU counter bank.
- Scans cores round-robin. For each core it sums that core's masked counters, compares the sum against the core's limit, and raises a sticky per-core interrupt.
- A period timer defines the replenishment window. At each boundary it pulses a counter-reset request and clears all quota state.
- Sits between the PMU counter bank and the interrupt controller, alongside the PMU configuration registers.

Parameters:
REG_WIDTH, 32, width of each counter.
N_COUNTERS, 9, number of counters in the bank.
N_CORES, 4, number of cores with independent quota.
PERIOD_WIDTH, 32, width of the window period register.
MAX_W (localparam), REG_WIDTH+$clog2(N_COUNTERS), accumulator/limit width.

Ports:
clk_i  in  1  clock.
rst_i  in  1  reset, synchronous, active-high.
softrst_i  in  1  soft reset from config regs, active-high; same effect as rst_i.
enable_i  in  1  scheduler enable; low freezes the FSM and timer, state is held.
counter_value_i  in  [N_COUNTERS][REG_WIDTH]  live counter values.
quota_mask_i  in  [N_CORES][N_COUNTERS]  per-core counter mask.
quota_limit_i  in  [N_CORES][MAX_W]  per-core limit.
period_i  in  PERIOD_WIDTH  window length in cycles; 0 disables replenishment.
intr_clr_i  in  N_CORES  per-core sticky-interrupt clear.
window_rst_o  out  1  one-cycle request to the counter bank to reset counters.
intr_quota_o  out  N_CORES  sticky quota-exceeded interrupts.
busy_o  out  1  high while in ACCUM or CHECK.

Behaviour:
- Reset (rst_i or softrst_i): FSM to CLEAR, core_idx=0, cnt_idx=0, acc=0, timer=0, old_mask=0.
  - Outputs after reset: intr_quota_o=0, window_rst_o=0, busy_o=0.
- FSM states: IDLE, CLEAR, ACCUM, CHECK.
  - IDLE: entered from any state when enable_i=0; all registers hold. When enable_i=1, resume the saved state (stored in a resume register).
  - CLEAR: acc=0, cnt_idx=0; next state ACCUM.
  - ACCUM: acc += zero-extend(mask[core_idx][cnt_idx] ? counter_value_i[cnt_idx] : 0). cnt_idx increments each cycle. After cnt_idx=N_COUNTERS-1, go to CHECK.
  - CHECK: if acc > quota_limit_i[core_idx] (strict), set intr[core_idx]. core_idx wraps at N_CORES-1 back to 0. Next state CLEAR.
- Timing:
  - Per-core latency is N_COUNTERS+2 cycles (CLEAR, N ACCUM, CHECK).
  - A full sweep takes N_CORES*(N_COUNTERS+2) cycles. With defaults: 44.
- Counters are not snapshotted; values are sampled in their ACCUM cycle.
- Mask change: quota_mask_i compared against registered old_mask.
  - On any difference, abort the scan: go to CLEAR, restart at core_idx=0.
  - Sticky interrupts are kept.
- Limit changes take effect at the next CHECK; they do not abort the scan.
- Period timer:
  - Counts while enable_i=1 and period_i!=0.
  - At timer==period_i-1: window_rst_o=1 for one cycle, timer=0, all intr bits cleared, scan aborted to CLEAR with core_idx=0.
  - period_i==1 gives a pulse every cycle, so CHECK is never reached. Legal, but the result is meaningless.
  - A period_i write does not reset the timer. If timer >= new period_i-1, the boundary fires on the next counting cycle.
- Interrupt priority in the same cycle: window boundary clear > CHECK set > intr_clr_i clear.
- Overflow: acc cannot overflow given the MAX_W width; no saturation is needed.

Optional Feature:
QUOTA_EARLY_EXIT_EN
- Defined: in ACCUM, if the updated acc > quota_limit_i[core_idx], go directly to CHECK without adding the remaining counters. Per-core latency is then between 3 and N_COUNTERS+2 cycles.
- Undefined: all N_COUNTERS are always accumulated, giving fixed latency. Interrupt results are identical whenever the sum only grows.

Decomposition:
- Package pmu_quota_pkg holds:
  - the FSM state enum (IDLE, CLEAR, ACCUM, CHECK);
  - the MAX_W computation function;
  - default parameter constants.
- One sub-module: pmu_quota_period_timer. It contains the period counter, the window_rst_o pulse and the period_i==0 disable.
- FSM, accumulator and sticky interrupts stay in the top module.

Test Plan:
- Single core hit (N_CORES=4, N_COUNTERS=9, period_i=0):
  - Stimulus: core0 mask=9'b000000011, counters[0]=10, counters[1]=5, limit0=14.
  - Response: intr_quota_o[0]=1 at core0's CHECK, 11 cycles after reset release; other bits stay 0.
- Boundary compare: same setup with limit0=15.
  - Response: intr never set (15 is not >15).
  - Then set intr_clr_i[0] while intr is 1: bit clears next cycle unless CHECK re-sets it in the same cycle (set wins).
- Window replenish: period_i=100, core2 over limit.
  - Response: window_rst_o pulses exactly at cycles 99, 199, ... after reset; intr[2] clears in the pulse cycle and re-asserts after the next scan.
- Mask change mid-scan: toggle quota_mask_i[1] while core1 is in ACCUM.
  - Response: FSM goes to CLEAR the next cycle with core_idx=0; existing intr bits are unchanged.
- Enable/reset: drop enable_i mid-ACCUM for 20 cycles.
  - Response: acc, cnt_idx and timer hold, then resume; busy_o=0 while disabled.
  - Assert rst_i mid-scan: all outputs 0 next cycle.
- QUOTA_EARLY_EXIT_EN: counters[0]=1000, limit0=500, full mask.
  - Response: CHECK is reached 2 cycles after CLEAR instead of 10; intr_quota_o[0]=1.
